// File: rtl/ladybird_bus_dma_if.sv
// ladybird_bus: single-initiator memory bus with a shared tri-state data path.
//   req/addr/wstrb : request from the initiator (wstrb==0 is a read, all-ones is a write)
//   gnt            : request accepted this cycle (req&gnt is the handshake)
//   data_gnt       : read data valid on data this cycle
//   data           : tri-state; initiator drives it during writes, responder during read data
// Modports: primary (initiator), secondary (responder).
interface ladybird_bus #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              req;
  logic              gnt;
  logic [XLEN-1:0]   addr;
  logic [STRB_W-1:0] wstrb;
  wire  [XLEN-1:0]   data;
  logic              data_gnt;

  modport primary (
    output req,
    output addr,
    output wstrb,
    input  gnt,
    input  data_gnt,
    inout  data
  );

  modport secondary (
    input  req,
    input  addr,
    input  wstrb,
    output gnt,
    output data_gnt,
    inout  data
  );
endinterface

// File: rtl/ladybird_bus_dma.sv
// ladybird_bus_dma: word-by-word memory copy engine on the ladybird bus.
// Each word is one read (RD_REQ -> RD_WAIT) followed by one write (WR_REQ);
// words never overlap. Addresses are word aligned and wrap modulo 2^XLEN.
// Ports:
//   clk, nrst          : clock, asynchronous active-low reset
//   start              : one-cycle launch pulse (honoured only when idle)
//   src_addr, dst_addr : byte addresses, low two bits ignored
//   length             : number of XLEN-bit words; zero completes without bus traffic
//   busy, done         : copy in progress / one-cycle completion pulse
//   bus                : ladybird_bus primary (initiator) modport
// Optional feature (macro LADYBIRD_DMA_IRQ_EN): sticky irq output set on done,
// cleared by irq_clr; a set in the same cycle as a clear wins.
module ladybird_bus_dma #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [XLEN-1:0]   src_addr,
  input  logic [XLEN-1:0]   dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
`ifdef LADYBIRD_DMA_IRQ_EN
  output logic              irq,
  input  logic              irq_clr,
`endif
  ladybird_bus.primary      bus
);

  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FIN     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    src_q, src_d;
  logic [XLEN-1:0]    dst_q, dst_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               req_q, req_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               data_oe_q, data_oe_d;

  // Next state, address/count bookkeeping and registered bus outputs
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    count_d   = count_q;
    data_d    = data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & ~XLEN'(3);
          dst_d   = dst_addr & ~XLEN'(3);
          count_d = length;
          state_d = (length != '0) ? RD_REQ : FIN;
        end
      end
      RD_REQ: begin
        if (req_q && bus.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // data_gnt is only looked at here, so one coinciding with the read
        // handshake cycle is never mistaken for read data.
        if (bus.data_gnt) begin
          data_d  = bus.data;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (req_q && bus.gnt) begin
          src_d   = src_q + XLEN'(4);
          dst_d   = dst_q + XLEN'(4);
          count_d = count_q - LEN_W'(1);
          state_d = (count_q == LEN_W'(1)) ? FIN : RD_REQ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    req_d     = (state_d == RD_REQ) || (state_d == WR_REQ);
    addr_d    = (state_d == RD_REQ) ? src_d :
                (state_d == WR_REQ) ? dst_d : '0;
    wstrb_d   = (state_d == WR_REQ) ? '1 : '0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
    data_oe_d = (state_d == WR_REQ);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      count_q   <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      count_q   <= count_d;
      data_q    <= data_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign bus.req   = req_q;
  assign bus.addr  = addr_q;
  assign bus.wstrb = wstrb_q;
  assign bus.data  = data_oe_q ? data_q : {XLEN{1'bz}};
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef LADYBIRD_DMA_IRQ_EN
  logic irq_q, irq_d;

  // Set on the cycle done is decoded and while done is visible, so a clear
  // presented alongside the done pulse never loses the interrupt.
  always_comb begin
    irq_d = done_d || done_q || (irq_q && !irq_clr);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/ladybird_bus_dma.md
LADYBIRD_BUS_DMA -- requirements
Module: ladybird_bus_dma

Interface
REQ-001 The block SHALL have parameter XLEN, default 32 (from ladybird_config), meaning the bus data width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning the width of the word-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that launches a copy.
REQ-006 The block SHALL have port src_addr, input, XLEN bits: the byte address of the source, sampled at start.
REQ-007 The block SHALL have port dst_addr, input, XLEN bits: the byte address of the destination, sampled at start.
REQ-008 The block SHALL have port length, input, LEN_W bits: the number of XLEN-bit words to copy, sampled at start.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a copy is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a copy completes.
REQ-011 The block SHALL have port bus, ladybird_bus.primary modport, carrying req, gnt, addr, wstrb, data (tri-state) and data_gnt; the block is the initiator of this bus.

Function
REQ-012 The block SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ and FIN.
REQ-013 In IDLE, start SHALL capture the source address, destination address and word count, each with bits [1:0] of both addresses forced to 0.
- Non-zero count: go to RD_REQ.
- Zero count: go to FIN; no bus traffic.
REQ-014 In RD_REQ, the block SHALL drive req=1, addr=the current source address and wstrb=4'b0000, held stable until gnt=1; on req&gnt it SHALL go to RD_WAIT.
REQ-015 In RD_WAIT, the block SHALL drive req=0.
- The first cycle with data_gnt=1: latch bus.data unmodified into the data register and go to WR_REQ.
- The wait for data_gnt is unbounded; no timeout.
REQ-016 In WR_REQ, the block SHALL drive req=1, addr=the current destination address, wstrb=4'b1111 and bus.data=the data register, all held until gnt=1.
REQ-017 On the WR_REQ handshake (req&gnt), the block SHALL:
- add 4 to the source and destination addresses, wrapping modulo 2^XLEN;
- subtract 1 from the count;
- go to RD_REQ if the new count is non-zero, otherwise go to FIN.
REQ-018 In FIN, the block SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 The block SHALL drive bus.data to high-impedance in every state except WR_REQ.
REQ-021 The block SHALL ignore start in every state other than IDLE.
REQ-022 The block SHALL ignore data_gnt outside RD_WAIT.
REQ-023 When gnt=1 with data_gnt=1 in the same cycle as RD_REQ, the block SHALL NOT take that data_gnt as the read data; read data is accepted only from the cycle after the read handshake.
REQ-024 Bus throughput SHALL be at most one read and one write per word, with no overlap between the words.

Reset
REQ-025 While nrst=0, the state SHALL be IDLE, with busy=0, done=0, req=0, addr=0, wstrb=0, the data register=0, all address/count registers=0 and bus.data=high-impedance.
REQ-026 If nrst is asserted in the middle of a copy, the transfer SHALL be abandoned, with no done pulse, and a new start SHALL be accepted in the first cycle after release.

Configuration
REQ-027 When LADYBIRD_DMA_IRQ_EN is defined, the block SHALL add ports irq (output, 1 bit) and irq_clr (input, 1 bit).
- irq is set in the cycle done=1 and stays set until irq_clr=1.
- If set and clear occur together, set wins.
- irq resets to 0.
REQ-028 When LADYBIRD_DMA_IRQ_EN is undefined, the ports irq and irq_clr SHALL be absent and the remaining behaviour SHALL be unchanged.

Verification
REQ-029 Basic copy: src=0x100, dst=0x200, length=3, gnt tied 1, responder with 2-cycle read latency -> reads at 0x100/0x104/0x108, writes at 0x200/0x204/0x208 with data matching the reads, done exactly once, busy then 0.
REQ-030 Zero length: start with length=0 -> busy=1 for 1 cycle, done pulse, req never asserted.
REQ-031 Back-pressure: gnt held 0 for 5 cycles on both the read and the write -> addr, wstrb and data stay stable throughout, no duplicate transaction, and the copy completes correctly.
REQ-032 Misaligned and wrapping addresses: src=0xFFFFFFFE, length=2 -> read addresses are 0xFFFFFFFC then 0x00000000.
REQ-033 Reset mid-copy: nrst pulsed low during RD_WAIT of word 2 of 4 -> all outputs return to reset values immediately, no done pulse, and a subsequent start with length=1 completes normally.
REQ-034 With LADYBIRD_DMA_IRQ_EN defined: irq rises with done and holds until irq_clr; with irq_clr=1 in the done cycle -> irq=1.
